// File: rtl/skeeball_game_ctrl.sv
// Skeeball game sequencer: edge-detects start and sensors, arbitrates one ball per event,
// and tracks score, balls and seconds through IDLE/PLAY/LOCK/OVER.
module skeeball_game_ctrl #(
    parameter int NUM_BALLS   = 9,
    parameter int GAME_SECS   = 60,
    parameter int LOCKOUT_CYC = 25000000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       tick_1hz,
    input  logic [4:0] hole,
    input  logic       miss,
    output logic [9:0] score,
    output logic [3:0] balls_left,
    output logic [6:0] secs_left,
    output logic [1:0] state,
    output logic       game_over
);

    localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        LOCK = 2'b10,
        OVER = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      score_q, score_d;
    logic [3:0]      balls_q, balls_d;
    logic [6:0]      secs_q, secs_d;
    logic [LW-1:0]   lock_q, lock_d;
    logic            start_q, miss_q;
    logic [4:0]      hole_q;

    logic            start_evt, miss_evt;
    logic [4:0]      hole_evt;
    logic            ball_evt;
    logic [9:0]      pts;

    assign start_evt = start & ~start_q;
    assign miss_evt  = miss & ~miss_q;
    assign hole_evt  = hole & ~hole_q;

    // Fixed-priority pick of a single winning sensor; losers that cycle are dropped.
    always_comb begin
        pts      = 10'd0;
        ball_evt = 1'b1;
        if (hole_evt[4])      pts = 10'd100;
        else if (hole_evt[3]) pts = 10'd40;
        else if (hole_evt[2]) pts = 10'd30;
        else if (hole_evt[1]) pts = 10'd20;
        else if (hole_evt[0]) pts = 10'd10;
        else if (miss_evt)    pts = 10'd0;
        else                  ball_evt = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        balls_d = balls_q;
        secs_d  = secs_q;
        lock_d  = lock_q;

        case (state_q)
            IDLE, OVER: begin
                if (start_evt) begin
                    state_d = PLAY;
                    score_d = 10'd0;
                    balls_d = 4'(NUM_BALLS);
                    secs_d  = 7'(GAME_SECS);
                    lock_d  = '0;
                end
            end
            PLAY: begin
                if (ball_evt && balls_q != 4'd0) begin
                    score_d = score_q + pts;
                    balls_d = balls_q - 4'd1;
                    if (balls_q == 4'd1) begin
                        state_d = OVER;
                    end else begin
                        state_d = LOCK;
                        lock_d  = LW'(LOCKOUT_CYC - 1);
                    end
                end
            end
            LOCK: begin
                if (lock_q == '0) state_d = PLAY;
                else              lock_d  = lock_q - LW'(1);
            end
            default: state_d = IDLE;
        endcase

        // The clock running out wins over any ball/lockout transition in the same cycle.
        if ((state_q == PLAY || state_q == LOCK) && tick_1hz && secs_q != 7'd0) begin
            secs_d = secs_q - 7'd1;
            if (secs_q == 7'd1) state_d = OVER;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            score_q <= 10'd0;
            balls_q <= 4'd0;
            secs_q  <= 7'd0;
            lock_q  <= '0;
            start_q <= 1'b0;
            miss_q  <= 1'b0;
            hole_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            balls_q <= balls_d;
            secs_q  <= secs_d;
            lock_q  <= lock_d;
            start_q <= start;
            miss_q  <= miss;
            hole_q  <= hole;
        end
    end

    assign score      = score_q;
    assign balls_left = balls_q;
    assign secs_left  = secs_q;
    assign state      = state_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Directed bench for skeeball_game_ctrl: main instance (60 s game) and a 2 s instance for timeout.
module tb_skeeball_game_ctrl;

    logic       clk;
    logic       Reset;
    logic       start, tick_1hz, miss;
    logic [4:0] hole;
    logic [9:0] score;
    logic [3:0] balls_left;
    logic [6:0] secs_left;
    logic [1:0] state;
    logic       game_over;

    logic       t_start, t_tick, t_miss;
    logic [4:0] t_hole;
    logic [9:0] t_score;
    logic [3:0] t_balls;
    logic [6:0] t_secs;
    logic [1:0] t_state;
    logic       t_go;

    int vectors;
    int miscompares;

    skeeball_game_ctrl #(.NUM_BALLS(9), .GAME_SECS(60), .LOCKOUT_CYC(4)) dut (
        .clk(clk), .Reset(Reset), .start(start), .tick_1hz(tick_1hz),
        .hole(hole), .miss(miss), .score(score), .balls_left(balls_left),
        .secs_left(secs_left), .state(state), .game_over(game_over)
    );

    skeeball_game_ctrl #(.NUM_BALLS(9), .GAME_SECS(2), .LOCKOUT_CYC(4)) dut_t (
        .clk(clk), .Reset(Reset), .start(t_start), .tick_1hz(t_tick),
        .hole(t_hole), .miss(t_miss), .score(t_score), .balls_left(t_balls),
        .secs_left(t_secs), .state(t_state), .game_over(t_go)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input int e_score, input int e_balls,
                              input int e_state);
        check({tag, "_score"}, 32'(score), 32'(e_score));
        check({tag, "_balls"}, 32'(balls_left), 32'(e_balls));
        check({tag, "_state"}, 32'(state), 32'(e_state));
    endtask

    task automatic ball(input logic [4:0] v);
        hole = v;
        cyc();
        hole = 5'd0;
        repeat (4) cyc();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset = 1'b0;
        start = 0; tick_1hz = 0; miss = 0; hole = 5'd0;
        t_start = 0; t_tick = 0; t_miss = 0; t_hole = 5'd0;

        // Reset state
        #12;
        check_main("rst", 0, 0, 0);
        check("rst_secs", 32'(secs_left), 0);
        check("rst_go", 32'(game_over), 0);
        Reset = 1'b1;
        cyc();

        // Start
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_main("start", 0, 9, 1);
        check("start_secs", 32'(secs_left), 60);
        check("start_go", 32'(game_over), 0);

        // Single hit then lockout; hole[0] during LOCK is discarded
        hole = 5'b10000;
        cyc();
        check_main("hit100", 100, 8, 2);
        hole = 5'b00001;
        cyc();
        check_main("lock_disc", 100, 8, 2);
        hole = 5'd0;
        cyc();
        cyc();
        check("lock_n3_state", 32'(state), 2);
        // Edge landing on the last LOCK cycle is still discarded
        hole = 5'b00001;
        cyc();
        check_main("lock_end", 100, 8, 1);
        cyc();
        check_main("held_no_retrig", 100, 8, 1);
        hole = 5'd0;
        cyc();

        // Arbitration: hole[1] and hole[3] together score only 40
        hole = 5'b01010;
        cyc();
        check_main("arb", 140, 7, 2);
        hole = 5'b00010;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("tick_in_lock", 32'(secs_left), 59);
        repeat (5) cyc();
        check_main("held_thru_lock", 140, 7, 1);
        hole = 5'd0;
        cyc();

        // Reset mid-LOCK is asynchronous
        hole = 5'b00100;
        cyc();
        check_main("hit30", 170, 6, 2);
        hole = 5'd0;
        #2;
        Reset = 1'b0;
        #1;
        check_main("async_rst", 0, 0, 0);
        check("async_rst_secs", 32'(secs_left), 0);
        check("async_rst_go", 32'(game_over), 0);
        Reset = 1'b1;
        cyc();

        // Ball exhaustion: 8 x hole[2] then miss
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_main("restart", 0, 9, 1);
        for (int i = 0; i < 8; i++) ball(5'b00100);
        check_main("eight_balls", 240, 1, 1);
        miss = 1'b1;
        cyc();
        miss = 1'b0;
        check_main("exhaust", 240, 0, 3);
        check("exhaust_go", 32'(game_over), 1);
        hole = 5'b10000;
        cyc();
        hole = 5'd0;
        check_main("over_hold", 240, 0, 3);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("over_tick_ign", 32'(secs_left), 60);

        // Restart from OVER
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_main("over_restart", 0, 9, 1);
        check("over_restart_secs", 32'(secs_left), 60);
        check("over_restart_go", 32'(game_over), 0);

        // Timeout with a simultaneous ball (GAME_SECS=2)
        t_start = 1'b1;
        cyc();
        t_start = 1'b0;
        check("t_start_secs", 32'(t_secs), 2);
        t_tick = 1'b1;
        cyc();
        t_tick = 1'b0;
        check("t_tick1_secs", 32'(t_secs), 1);
        check("t_tick1_state", 32'(t_state), 1);
        t_tick = 1'b1;
        t_hole = 5'b00001;
        cyc();
        t_tick = 1'b0;
        t_hole = 5'd0;
        check("t_end_score", 32'(t_score), 10);
        check("t_end_secs", 32'(t_secs), 0);
        check("t_end_balls", 32'(t_balls), 8);
        check("t_end_state", 32'(t_state), 3);
        check("t_end_go", 32'(t_go), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
